// File: rtl/tt_um_aleena_pwm_if.sv
// Host-side pin bundle of the Tiny Tapeout user tile.
//   ena     : tile enable from the harness
//   ui_in   : [7] write strobe, [6] global enable, [2:0] register address
//   uio_in  : write data byte
//   uio_out : bidirectional pin outputs (unused, driven 0)
//   uio_oe  : bidirectional pin output enables (all inputs, driven 0)
//   uo_out  : PWM outputs and period-start pulse
// master = harness / host side, slave = the PWM tile.
interface tt_um_aleena_pwm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uio_out,
        input  uio_oe,
        input  uo_out
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uio_out,
        output uio_oe,
        output uo_out
    );
endinterface

// File: rtl/tt_um_aleena_pwm.sv
// Multi-channel PWM tile: shared free-running WIDTH-bit period counter,
// programmable prescaler and double-buffered duty registers written through
// a byte-wide host port.
//   clk   : clock
//   rst_n : synchronous reset, active-low
//   bus   : tile pins (slave side), see tt_um_aleena_pwm_if
//     uo_out[CHANNELS-1:0] PWM waveforms, uo_out[7] one-clock period-start pulse
module tt_um_aleena_pwm #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_um_aleena_pwm_if.slave     bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic                 strobe_r;
    logic [7:0]           prescale_r;
    logic [7:0]           psc_r;
    logic [WIDTH-1:0]     cnt_r;
    logic [WIDTH-1:0]     pending_r [CHANNELS];
    logic [WIDTH-1:0]     active_r  [CHANNELS];
    logic [CHANNELS-1:0]  pwm_r;
    logic                 pulse_r;

    logic                 run_s;
    logic                 wr_s;
    logic                 tick_s;
    logic                 wrap_s;
    logic [2:0]           addr_s;
    logic [7:0]           uo_s;
    logic                 unused_s;

    // Run gating, write edge detect, prescaler tick and period wrap.
    always_comb begin
        run_s  = bus.ui_in[6] & bus.ena;
        wr_s   = bus.ui_in[7] & ~strobe_r;
        addr_s = bus.ui_in[2:0];
        // >= so that lowering prescale below the running count ticks at once
        tick_s = run_s && (psc_r >= prescale_r);
        wrap_s = tick_s && (cnt_r == CNT_MAX);
    end

    // Host write port: strobe history, prescale and pending duty registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_r   <= 1'b0;
            prescale_r <= 8'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending_r[i] <= '0;
            end
        end else begin
            strobe_r <= bus.ui_in[7];
            if (wr_s && (addr_s == 3'd7)) begin
                prescale_r <= bus.uio_in;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_s && (addr_s == 3'(i))) begin
                    pending_r[i] <= bus.uio_in[WIDTH-1:0];
                end
            end
        end
    end

    // Prescaler and period counter; both restart from 0 whenever run drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc_r <= 8'd0;
            cnt_r <= '0;
        end else if (!run_s) begin
            psc_r <= 8'd0;
            cnt_r <= '0;
        end else if (tick_s) begin
            psc_r <= 8'd0;
            cnt_r <= cnt_r + WIDTH'(1);
        end else begin
            psc_r <= psc_r + 8'd1;
        end
    end

    // Active duty follows pending while stopped, otherwise only at a wrap,
    // so a period in progress never sees a half-updated duty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= '0;
            end
        end else if (!run_s || wrap_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= pending_r[i];
            end
        end
    end

    // Registered PWM compare and period-start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_r   <= '0;
            pulse_r <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_r[i] <= run_s && (cnt_r < active_r[i]);
            end
            pulse_r <= wrap_s;
        end
    end

    // Output byte assembly; unassigned bits stay 0.
    always_comb begin
        uo_s                 = 8'h00;
        uo_s[CHANNELS-1:0]   = pwm_r;
        uo_s[7]              = pulse_r;
    end

    assign bus.uo_out  = uo_s;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
    // Pins that carry no function in this tile.
    assign unused_s    = ^{bus.ui_in[5:3], bus.uio_in};

endmodule

// File: tb/tb_tt_um_aleena_pwm.sv
// Directed self-checking bench for tt_um_aleena_pwm (CHANNELS=4, WIDTH=8).
module tb_tt_um_aleena_pwm;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   hi;
    int   per;
    int   n;

    tt_um_aleena_pwm_if bus ();

    tt_um_aleena_pwm #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        n_total++;
        $error("FAIL %s observed=timeout expected=pulse", tag);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        bus.ui_in  = {1'b1, bus.ui_in[6], 3'b000, a};
        bus.uio_in = d;
        step();
        bus.ui_in[7] = 1'b0;
        step();
    endtask

    // Waits for a period-start pulse, then counts high samples of channel ch
    // and samples until the next pulse. Optionally issues a one-cycle write
    // whose edge is wr_at samples after the starting pulse sample + 1.
    task automatic measure(input int ch, input int wr_at, input logic [2:0] wa,
                           input logic [7:0] wd, output int h, output int p);
        int w;
        w = 0;
        h = 0;
        p = 0;
        while (bus.uo_out[7] !== 1'b1 && w < 5000) begin
            step();
            w++;
        end
        if (w >= 5000) begin
            timeout("wait_pulse");
        end else begin
            while (1) begin
                h += int'(bus.uo_out[ch]);
                p++;
                if (p - 1 == wr_at) begin
                    bus.ui_in  = {1'b1, bus.ui_in[6], 3'b000, wa};
                    bus.uio_in = wd;
                end else if (p - 1 == wr_at + 1) begin
                    bus.ui_in[7] = 1'b0;
                end
                step();
                if (bus.uo_out[7] === 1'b1 || p > 5000) break;
            end
            bus.ui_in[7] = 1'b0;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Reset with all inputs high
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'hFF;
        bus.uio_in = 8'hFF;
        step();
        chk("rst_uo_out", int'(bus.uo_out), 0);
        chk("rst_uio_oe", int'(bus.uio_oe), 0);
        chk("rst_uio_out", int'(bus.uio_out), 0);
        step();
        step();
        chk("rst_uo_out_held", int'(bus.uo_out), 0);
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_uo_out", int'(bus.uo_out), 0);

        // duty0=64, prescale 0
        host_write(3'd0, 8'd64);
        bus.ui_in = 8'h40;
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t2_hi", hi, 64);
        chk("t2_period", per, 256);
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t2_period_again", per, 256);

        // Mid-period write 64->200 keeps 64 for the current period
        measure(0, 10, 3'd0, 8'd200, hi, per);
        chk("t4_mid_keep_hi", hi, 64);
        chk("t4_mid_keep_period", per, 256);
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t4_new_hi", hi, 200);
        // Write landing exactly on the wrap edge applies one period later
        measure(0, 255, 3'd0, 8'd30, hi, per);
        chk("t4_wrapwr_cur_hi", hi, 200);
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t4_wrapwr_next_hi", hi, 200);
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t4_wrapwr_later_hi", hi, 30);

        // duty 255 and duty 0
        host_write(3'd3, 8'd255);
        host_write(3'd2, 8'd0);
        measure(3, -1, 3'd0, 8'd0, hi, per);
        chk("t5_full_hi", hi, 255);
        chk("t5_full_period", per, 256);
        measure(2, -1, 3'd0, 8'd0, hi, per);
        chk("t5_zero_hi", hi, 0);

        // prescale=3, duty1=128
        host_write(3'd7, 8'd3);
        host_write(3'd1, 8'd128);
        measure(1, -1, 3'd0, 8'd0, hi, per);
        chk("t3_hi", hi, 512);
        chk("t3_period", per, 1024);
        measure(0, -1, 3'd0, 8'd0, hi, per);
        chk("t3_ch0_hi", hi, 120);

        // Held strobe: only the first value is stored
        host_write(3'd7, 8'd0);
        bus.ui_in  = 8'hC1;
        bus.uio_in = 8'd40;
        step();
        for (int i = 0; i < 9; i++) begin
            bus.uio_in = 8'(100 + i);
            step();
        end
        bus.ui_in = 8'h40;
        step();
        measure(1, -1, 3'd0, 8'd0, hi, per);
        chk("t6_strobe_hi", hi, 40);
        chk("t6_strobe_period", per, 256);

        // Drop run mid-period, then re-enable
        for (int i = 0; i < 10; i++) step();
        chk("t6_ch3_running", int'(bus.uo_out[3]), 1);
        bus.ui_in = 8'h00;
        step();
        chk("t6_stop_uo_out", int'(bus.uo_out), 0);
        step();
        step();
        chk("t6_stop_held", int'(bus.uo_out), 0);
        bus.ui_in = 8'h40;
        step();
        chk("t6_restart_low", int'(bus.uo_out[3:0]), 4'hB);
        n = 0;
        while (bus.uo_out[7] !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        chk("t6_restart_cnt0", n, 255);

        // ena low behaves as run low
        for (int i = 0; i < 5; i++) step();
        bus.ena = 1'b0;
        step();
        chk("ena_low_uo_out", int'(bus.uo_out), 0);
        bus.ena = 1'b1;

        // Reset mid-period clears outputs and duty registers
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        step();
        chk("midrst_uo_out", int'(bus.uo_out), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("midrst_duty_cleared", int'(bus.uo_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
